// File: rtl/stack_ctrl.sv
// Descending stack-pointer controller: turns single-cycle push/pop/peek
// requests into one-cycle accesses on a combinational-read stack memory.
module stack_ctrl #(
    parameter int DW = 11,
    parameter int AW = 8,
    parameter logic [AW-1:0] TOP = '1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          peek,
    input  logic [DW-1:0] push_data,
    input  logic          clr_err,
    output logic          ready,
    output logic [DW-1:0] pop_data,
    output logic          pop_valid,
    output logic [AW-1:0] sp,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow,
    output logic [AW-1:0] address,
    output logic [DW-1:0] write_data_stack,
    input  logic [DW-1:0] read_data_stack,
    output logic          MemWrite,
    output logic          MemRead
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t        state, next_state;
    logic [DW-1:0] wdata;
    logic          is_pop;
    logic [2:0]    req;
    logic          one_req, do_push, do_read, ovf_evt, unf_evt;

    assign full  = (count == DEPTH);
    assign empty = (count == '0);

    // Conflicting requests (more than one strobe high) are dropped silently.
    assign req     = {push, pop, peek};
    assign one_req = (req == 3'b100) || (req == 3'b010) || (req == 3'b001);
    assign do_push = (state == IDLE) && one_req && push && !full;
    assign ovf_evt = (state == IDLE) && one_req && push && full;
    assign do_read = (state == IDLE) && one_req && (pop || peek) && !empty;
    assign unf_evt = (state == IDLE) && one_req && (pop || peek) && empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (do_push)      next_state = WRITE;
                   else if (do_read) next_state = READ;
            WRITE: next_state = IDLE;
            READ:  next_state = RESP;
            RESP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready            = (state == IDLE);
        pop_valid        = (state == RESP);
        MemWrite         = 1'b0;
        MemRead          = 1'b0;
        address          = sp;
        write_data_stack = '0;
        case (state)
            WRITE: begin
                MemWrite         = 1'b1;
                write_data_stack = wdata;
            end
            READ: begin
                MemRead = 1'b1;
                address = sp + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= TOP;
            count     <= '0;
            wdata     <= '0;
            is_pop    <= 1'b0;
            pop_data  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push) wdata  <= push_data;
            if (do_read) is_pop <= pop;
            if (state == WRITE) begin
                sp    <= sp - 1'b1;
                count <= count + 1'b1;
            end
            if (state == READ) begin
                pop_data <= read_data_stack;
                if (is_pop) begin
                    sp    <= sp + 1'b1;
                    count <= count - 1'b1;
                end
            end
            // A new error event in the same cycle outranks clr_err.
            if (ovf_evt)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (unf_evt)      underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural stack memory, vector table, scoreboard
// for pop/peek data, and hand sequences for full, held-request and reset cases.
module tb_stack_ctrl;
    localparam int DW = 11;
    localparam int AW = 8;
    localparam int OP_PUSH = 0, OP_POP = 1, OP_PEEK = 2, OP_CLR = 3, OP_BOTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push, pop, peek, clr_err;
    logic [DW-1:0] push_data;
    logic          ready, pop_valid, full, empty, overflow, underflow;
    logic [DW-1:0] pop_data, write_data_stack, read_data_stack;
    logic [AW-1:0] sp, address;
    logic [AW:0]   count;
    logic          MemWrite, MemRead;

    logic [DW-1:0] mem [0:255];
    int            n_cmp = 0, n_err = 0;
    int            wr_cnt = 0, rd_cnt = 0, last_addr = -1;
    int            sb[$];

    stack_ctrl dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .peek(peek),
        .push_data(push_data), .clr_err(clr_err), .ready(ready),
        .pop_data(pop_data), .pop_valid(pop_valid), .sp(sp), .count(count),
        .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
        .address(address), .write_data_stack(write_data_stack),
        .read_data_stack(read_data_stack), .MemWrite(MemWrite), .MemRead(MemRead)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (MemWrite) mem[address] <= write_data_stack;
    assign read_data_stack = mem[address];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (MemWrite) begin wr_cnt++; last_addr = int'(address); end
        if (MemRead)  begin rd_cnt++; last_addr = int'(address); end
        if (MemWrite && MemRead) chk("strobe_overlap", 1, 0);
        if (pop_valid) begin
            if (sb.size() == 0) chk("unexpected_pop_valid", 1, 0);
            else chk("pop_data", int'($signed(pop_data)), sb.pop_front());
        end
    end

    task automatic issue(input int op, input int data);
        push      = (op == OP_PUSH) || (op == OP_BOTH);
        pop       = (op == OP_POP)  || (op == OP_BOTH);
        peek      = (op == OP_PEEK);
        clr_err   = (op == OP_CLR);
        push_data = DW'(data);
        @(posedge clk); #1;
        push = 0; pop = 0; peek = 0; clr_err = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("ready_wait", int'(ready), 1);
    endtask

    typedef struct {
        int op; int data;
        int exp_sp; int exp_cnt; int exp_empty; int exp_ovf; int exp_unf;
        int exp_acc; int exp_addr;
    } vec_t;

    vec_t vt[11];

    initial begin
        int acc0, w0;
        // op data sp cnt empty ovf unf acc addr
        vt[0]  = '{OP_PUSH, 5,   254, 1, 0, 0, 0, 1, 255};
        vt[1]  = '{OP_PUSH, -1,  253, 2, 0, 0, 0, 1, 254};
        vt[2]  = '{OP_POP,  -1,  254, 1, 0, 0, 0, 1, 254};
        vt[3]  = '{OP_POP,  5,   255, 0, 1, 0, 0, 1, 255};
        vt[4]  = '{OP_POP,  0,   255, 0, 1, 0, 1, 0, 0};
        vt[5]  = '{OP_PEEK, 0,   255, 0, 1, 0, 1, 0, 0};
        vt[6]  = '{OP_CLR,  0,   255, 0, 1, 0, 0, 0, 0};
        vt[7]  = '{OP_BOTH, 9,   255, 0, 1, 0, 0, 0, 0};
        vt[8]  = '{OP_PUSH, 100, 254, 1, 0, 0, 0, 1, 255};
        vt[9]  = '{OP_PEEK, 100, 254, 1, 0, 0, 0, 1, 255};
        vt[10] = '{OP_POP,  100, 255, 0, 1, 0, 0, 1, 255};

        rst_n = 0; push = 0; pop = 0; peek = 0; clr_err = 0; push_data = '0;
        #12;
        chk("rst_ready", int'(ready), 1);
        chk("rst_sp", int'(sp), 255);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_memwrite", int'(MemWrite), 0);
        chk("rst_memread", int'(MemRead), 0);
        chk("rst_address", int'(address), 255);
        chk("rst_wdata", int'(write_data_stack), 0);
        chk("rst_pop_data", int'(pop_data), 0);
        chk("rst_pop_valid", int'(pop_valid), 0);
        chk("rst_flags", int'({overflow, underflow}), 0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            wait_ready();
            acc0 = wr_cnt + rd_cnt;
            if ((vt[i].op == OP_POP || vt[i].op == OP_PEEK) && vt[i].exp_acc == 1)
                sb.push_back(vt[i].data);
            issue(vt[i].op, vt[i].data);
            if (vt[i].exp_acc == 1) begin
                chk($sformatf("v%0d_busy", i), int'(ready), 0);
                if (vt[i].op == OP_PUSH) begin
                    chk($sformatf("v%0d_memwrite", i), int'(MemWrite), 1);
                end else begin
                    chk($sformatf("v%0d_pv_early", i), int'(pop_valid), 0);
                    @(posedge clk); #1;
                    chk($sformatf("v%0d_pv", i), int'(pop_valid), 1);
                end
                @(posedge clk); #1;
                chk($sformatf("v%0d_ready_back", i), int'(ready), 1);
                chk($sformatf("v%0d_pv_off", i), int'(pop_valid), 0);
            end
            wait_ready();
            chk($sformatf("v%0d_sp", i), int'(sp), vt[i].exp_sp);
            chk($sformatf("v%0d_count", i), int'(count), vt[i].exp_cnt);
            chk($sformatf("v%0d_empty", i), int'(empty), vt[i].exp_empty);
            chk($sformatf("v%0d_ovf", i), int'(overflow), vt[i].exp_ovf);
            chk($sformatf("v%0d_unf", i), int'(underflow), vt[i].exp_unf);
            chk($sformatf("v%0d_access", i), wr_cnt + rd_cnt - acc0, vt[i].exp_acc);
            if (vt[i].exp_acc == 1) chk($sformatf("v%0d_addr", i), last_addr, vt[i].exp_addr);
        end

        // Fill to capacity, then overflow and peek the top.
        for (int v = 0; v < 256; v++) begin
            wait_ready();
            issue(OP_PUSH, v);
        end
        wait_ready();
        chk("full_flag", int'(full), 1);
        chk("full_count", int'(count), 256);
        chk("full_sp", int'(sp), 255);
        w0 = wr_cnt;
        issue(OP_PUSH, 77);
        wait_ready();
        chk("ovf_no_write", wr_cnt - w0, 0);
        chk("ovf_flag", int'(overflow), 1);
        sb.push_back(255);
        issue(OP_PEEK, 0);
        wait_ready();
        chk("peek_full_sp", int'(sp), 255);
        chk("peek_full_count", int'(count), 256);
        chk("peek_full_addr", last_addr, 0);
        issue(OP_CLR, 0);
        chk("clr_ovf", int'(overflow), 0);

        rst_n = 0; #1; rst_n = 1;
        @(posedge clk); #1;
        chk("rst2_count", int'(count), 0);

        // Push held high across busy cycles: one accept per idle cycle.
        w0 = wr_cnt;
        push = 1; push_data = 11'd7;
        repeat (6) begin @(posedge clk); #1; end
        push = 0;
        wait_ready();
        chk("held_writes", wr_cnt - w0, 3);
        chk("held_count", int'(count), 3);
        chk("held_sp", int'(sp), 252);

        // Reset asserted mid-write.
        issue(OP_PUSH, 3);
        chk("mid_memwrite", int'(MemWrite), 1);
        #1 rst_n = 0; #1;
        chk("abort_memwrite", int'(MemWrite), 0);
        chk("abort_sp", int'(sp), 255);
        chk("abort_count", int'(count), 0);
        chk("abort_ready", int'(ready), 1);
        chk("abort_flags", int'({overflow, underflow}), 0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
